// File: rtl/tree_router3_pkg.sv
// Shared types and routing helpers for the 3-port binary-tree NoC node.
package tree_router_pkg;

  localparam int WIDTH    = 32;
  localparam int ADDR_W   = 3;
  localparam int DEST_LSB = 24;

  typedef logic [WIDTH-1:0]  pkt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {PORT_C1, PORT_C2, PORT_P} port_e;

  function automatic addr_t dest_of(input pkt_t pkt);
    return pkt[DEST_LSB +: ADDR_W];
  endfunction

  // Parent traffic splits on the highest address bit outside the subtree mask.
  function automatic port_e route(input port_e in_port, input addr_t dest,
                                  input addr_t address, input addr_t mask);
    logic  sel;
    port_e tgt;
    sel = 1'b0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (!mask[i]) sel = dest[i];
    end
    if (in_port == PORT_P) begin
      tgt = sel ? PORT_C2 : PORT_C1;
    end else if ((dest & mask) == (address & mask)) begin
      tgt = (in_port == PORT_C1) ? PORT_C2 : PORT_C1;
    end else begin
      tgt = PORT_P;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/tree_router3_if.sv
// Valid/ready packet stream between router ports and their neighbours.
interface tree_router3_if;
  import tree_router_pkg::*;

  logic valid;
  logic ready;
  pkt_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tree_router3_merge2.sv
// 2:1 round-robin merge into a one-entry output register.
// ROUTER_STATS_EN adds a saturating count of completed output transfers.
module router_merge2
  import tree_router_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  pkt_t data0_i,
  input  pkt_t data1_i,
  output logic gnt0_o,
  output logic gnt1_o,
  tree_router3_if.master out
`ifdef ROUTER_STATS_EN
  ,
  output logic [15:0] cnt_o
`endif
);

  logic valid_q, valid_d;
  logic ptr_q, ptr_d;
  pkt_t data_q, data_d;
  logic free;

  // ptr_q names the source that wins the next tie.
  always_comb begin
    free    = !rst && (!valid_q || out.ready);
    gnt0_o  = free && req0_i && (!req1_i || !ptr_q);
    gnt1_o  = free && req1_i && (!req0_i || ptr_q);
    valid_d = valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (free) begin
      valid_d = gnt0_o | gnt1_o;
      if (gnt0_o) begin
        data_d = data0_i;
        ptr_d  = 1'b1;
      end else if (gnt1_o) begin
        data_d = data1_i;
        ptr_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ptr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out.valid = valid_q;
  assign out.data  = data_q;

`ifdef ROUTER_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (valid_q && out.ready && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/tree_router3.sv
// Binary-tree NoC node: per-input route decode feeding three round-robin output merges.
// ROUTER_STATS_EN adds per-output transfer counters.
module tree_router3
  import tree_router_pkg::*;
#(
  parameter addr_t ADDRESS = 3'b000,
  parameter addr_t MASK    = 3'b000
) (
  input  logic clk,
  input  logic rst,
  tree_router3_if.slave  c1_in,
  tree_router3_if.slave  c2_in,
  tree_router3_if.slave  p_in,
  tree_router3_if.master c1_out,
  tree_router3_if.master c2_out,
  tree_router3_if.master p_out
`ifdef ROUTER_STATS_EN
  ,
  output logic [15:0] c1_out_cnt,
  output logic [15:0] c2_out_cnt,
  output logic [15:0] p_out_cnt
`endif
);

  port_e tgt_c1, tgt_c2, tgt_p;
  logic  g_c1_0, g_c1_1, g_c2_0, g_c2_1, g_p_0, g_p_1;

  assign tgt_c1 = route(PORT_C1, dest_of(c1_in.data), ADDRESS, MASK);
  assign tgt_c2 = route(PORT_C2, dest_of(c2_in.data), ADDRESS, MASK);
  assign tgt_p  = route(PORT_P,  dest_of(p_in.data),  ADDRESS, MASK);

  // Each input targets exactly one output, so at most one grant term is live.
  assign c1_in.ready = g_c2_0 | g_p_0;
  assign c2_in.ready = g_c1_0 | g_p_1;
  assign p_in.ready  = g_c1_1 | g_c2_1;

  router_merge2 u_c1_out (
    .clk    (clk),
    .rst    (rst),
    .req0_i (c2_in.valid && (tgt_c2 == PORT_C1)),
    .req1_i (p_in.valid  && (tgt_p  == PORT_C1)),
    .data0_i(c2_in.data),
    .data1_i(p_in.data),
    .gnt0_o (g_c1_0),
    .gnt1_o (g_c1_1),
    .out    (c1_out)
`ifdef ROUTER_STATS_EN
    ,
    .cnt_o  (c1_out_cnt)
`endif
  );

  router_merge2 u_c2_out (
    .clk    (clk),
    .rst    (rst),
    .req0_i (c1_in.valid && (tgt_c1 == PORT_C2)),
    .req1_i (p_in.valid  && (tgt_p  == PORT_C2)),
    .data0_i(c1_in.data),
    .data1_i(p_in.data),
    .gnt0_o (g_c2_0),
    .gnt1_o (g_c2_1),
    .out    (c2_out)
`ifdef ROUTER_STATS_EN
    ,
    .cnt_o  (c2_out_cnt)
`endif
  );

  router_merge2 u_p_out (
    .clk    (clk),
    .rst    (rst),
    .req0_i (c1_in.valid && (tgt_c1 == PORT_P)),
    .req1_i (c2_in.valid && (tgt_c2 == PORT_P)),
    .data0_i(c1_in.data),
    .data1_i(c2_in.data),
    .gnt0_o (g_p_0),
    .gnt1_o (g_p_1),
    .out    (p_out)
`ifdef ROUTER_STATS_EN
    ,
    .cnt_o  (p_out_cnt)
`endif
  );

endmodule

// File: tb/tb_tree_router3.sv
// Scoreboard bench for tree_router3 (ADDRESS=010, MASK=110); stats checks need ROUTER_STATS_EN.
module tb_tree_router3;
  import tree_router_pkg::*;

  localparam int C1 = 0;
  localparam int C2 = 1;
  localparam int P  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tree_router3_if c1_in_if ();
  tree_router3_if c2_in_if ();
  tree_router3_if p_in_if ();
  tree_router3_if c1_out_if ();
  tree_router3_if c2_out_if ();
  tree_router3_if p_out_if ();

`ifdef ROUTER_STATS_EN
  logic [15:0] c1_cnt, c2_cnt, p_cnt;
`endif

  tree_router3 #(.ADDRESS(3'b010), .MASK(3'b110)) dut (
    .clk   (clk),
    .rst   (rst),
    .c1_in (c1_in_if),
    .c2_in (c2_in_if),
    .p_in  (p_in_if),
    .c1_out(c1_out_if),
    .c2_out(c2_out_if),
    .p_out (p_out_if)
`ifdef ROUTER_STATS_EN
    ,
    .c1_out_cnt(c1_cnt),
    .c2_out_cnt(c2_cnt),
    .p_out_cnt (p_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_c1[$];
  logic [31:0] exp_c2[$];
  logic [31:0] exp_p[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int port, input logic v, input logic [31:0] d);
    case (port)
      C1:      begin c1_in_if.valid = v; c1_in_if.data = d; end
      C2:      begin c2_in_if.valid = v; c2_in_if.data = d; end
      default: begin p_in_if.valid  = v; p_in_if.data  = d; end
    endcase
  endtask

  function automatic logic in_ready(input int port);
    case (port)
      C1:      return c1_in_if.ready;
      C2:      return c2_in_if.ready;
      default: return p_in_if.ready;
    endcase
  endfunction

  task automatic push_exp(input int dst, input logic [31:0] d);
    case (dst)
      C1:      exp_c1.push_back(d);
      C2:      exp_c2.push_back(d);
      default: exp_p.push_back(d);
    endcase
  endtask

  // Holds valid until the handshake is seen, then releases it after the edge.
  task automatic send(input int port, input logic [31:0] d, input int dst, input bit push);
    bit ok;
    ok = 1'b0;
    drive(port, 1'b1, d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready(port)) begin
        ok = 1'b1;
        if (push) push_exp(dst, d);
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: port %0d data %h got ready=0, expected ready=1", port, d);
    end
    @(posedge clk);
    #1;
    drive(port, 1'b0, 32'h0);
  endtask

  task automatic mon_check(input int dst, input logic [31:0] act);
    logic [31:0] e;
    bit          have;
    have = 1'b0;
    e    = '0;
    case (dst)
      C1:      if (exp_c1.size() > 0) begin e = exp_c1.pop_front(); have = 1'b1; end
      C2:      if (exp_c2.size() > 0) begin e = exp_c2.pop_front(); have = 1'b1; end
      default: if (exp_p.size()  > 0) begin e = exp_p.pop_front();  have = 1'b1; end
    endcase
    n_checks++;
    if (!have) begin
      n_fail++;
      $display("FAIL out%0d_unexpected: got %h, expected no packet", dst, act);
    end else if (act !== e) begin
      n_fail++;
      $display("FAIL out%0d_data: got %h, expected %h", dst, act, e);
    end else begin
      $display("out%0d transfer %h ok", dst, act);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (c1_out_if.valid && c1_out_if.ready) mon_check(C1, c1_out_if.data);
      if (c2_out_if.valid && c2_out_if.ready) mon_check(C2, c2_out_if.data);
      if (p_out_if.valid  && p_out_if.ready)  mon_check(P,  p_out_if.data);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    drive(C1, 1'b0, 32'h0);
    drive(C2, 1'b0, 32'h0);
    drive(P, 1'b1, 32'h01000009);
    c1_out_if.ready = 1'b1;
    c2_out_if.ready = 1'b1;
    p_out_if.ready  = 1'b1;

    // Reset state: outputs idle, inputs refused even with valid held.
    #2;
    chk("rst_c1_valid", {31'b0, c1_out_if.valid}, 32'd0);
    chk("rst_c2_valid", {31'b0, c2_out_if.valid}, 32'd0);
    chk("rst_p_valid",  {31'b0, p_out_if.valid},  32'd0);
    chk("rst_c2_data",  c2_out_if.data, 32'h0);
    chk("rst_p_ready",  {31'b0, p_in_if.ready}, 32'd0);
    cycles(2);
    chk("rst_hold_p_ready",  {31'b0, p_in_if.ready}, 32'd0);
    chk("rst_hold_c2_valid", {31'b0, c2_out_if.valid}, 32'd0);
    drive(P, 1'b0, 32'h0);
    rst = 1'b0;
    cycles(1);

    // Parent routing on dest bit 0, one-cycle latency.
    send(P, 32'h01000009, C2, 1'b1);
    chk("lat_c2_valid", {31'b0, c2_out_if.valid}, 32'd1);
    chk("lat_c2_data",  c2_out_if.data, 32'h01000009);
    send(P, 32'h0200000C, C1, 1'b1);
    chk("lat_c1_valid", {31'b0, c1_out_if.valid}, 32'd1);
    chk("lat_c1_data",  c1_out_if.data, 32'h0200000C);
    send(P, 32'h0300000F, C2, 1'b1);
    chk("lat_c2b_data", c2_out_if.data, 32'h0300000F);
    cycles(2);

    // Child routing: in-subtree to sibling, out-of-subtree to parent.
    send(C1, 32'h03000001, C2, 1'b1);
    send(C1, 32'h05000001, P, 1'b1);
    cycles(2);
    chk("c1_never_valid", {31'b0, c1_out_if.valid}, 32'd0);

    // Stall: held output stays stable, blocked P input does not stop C2 -> C1.
    c2_out_if.ready = 1'b0;
    send(P, 32'h01000009, C2, 1'b1);
    fork
      send(P, 32'h03000005, C2, 1'b1);
      send(C2, 32'h02000000, C1, 1'b1);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("stall_c2_valid", {31'b0, c2_out_if.valid}, 32'd1);
          chk("stall_c2_data",  c2_out_if.data, 32'h01000009);
          chk("stall_p_ready",  {31'b0, p_in_if.ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        c2_out_if.ready = 1'b1;
      end
    join
    cycles(2);
    chk("stall_c2_drained", {31'b0, c2_out_if.valid}, 32'd0);

    // Asynchronous reset mid-stream discards the held packet.
    c2_out_if.ready = 1'b0;
    send(P, 32'h01000009, C2, 1'b0);
    drive(P, 1'b1, 32'h03000005);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_c2_valid", {31'b0, c2_out_if.valid}, 32'd0);
    chk("arst_c2_data",  c2_out_if.data, 32'h0);
    chk("arst_c1_valid", {31'b0, c1_out_if.valid}, 32'd0);
    chk("arst_p_valid",  {31'b0, p_out_if.valid},  32'd0);
    chk("arst_p_ready",  {31'b0, p_in_if.ready}, 32'd0);
    drive(P, 1'b0, 32'h0);
    exp_c1.delete();
    exp_c2.delete();
    exp_p.delete();
    cycles(1);
    rst = 1'b0;
    c2_out_if.ready = 1'b1;
    cycles(1);
    // First-listed source (C2 in) wins the first tie on C1 out after reset.
    push_exp(C1, 32'h02000011);
    push_exp(C1, 32'h02000022);
    fork
      send(C2, 32'h02000011, C1, 1'b0);
      send(P,  32'h02000022, C1, 1'b0);
    join
    cycles(3);

    // Round-robin on P out: C1, C2, C1, C2.
    push_exp(P, 32'h05000001);
    push_exp(P, 32'h05000002);
    push_exp(P, 32'h05000003);
    push_exp(P, 32'h05000004);
    fork
      begin
        send(C1, 32'h05000001, P, 1'b0);
        send(C1, 32'h05000003, P, 1'b0);
      end
      begin
        send(C2, 32'h05000002, P, 1'b0);
        send(C2, 32'h05000004, P, 1'b0);
      end
    join
    cycles(3);

`ifdef ROUTER_STATS_EN
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("cnt_rst_c2", {16'b0, c2_cnt}, 32'd0);
    cycles(1);
    rst = 1'b0;
    send(P, 32'h01000009, C2, 1'b1);
    send(P, 32'h01000009, C2, 1'b1);
    send(P, 32'h01000009, C2, 1'b1);
    cycles(3);
    chk("cnt_c2", {16'b0, c2_cnt}, 32'd3);
    chk("cnt_c1", {16'b0, c1_cnt}, 32'd0);
    chk("cnt_p",  {16'b0, p_cnt},  32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("cnt_clr_c2", {16'b0, c2_cnt}, 32'd0);
    chk("cnt_clr_c1", {16'b0, c1_cnt}, 32'd0);
    chk("cnt_clr_p",  {16'b0, p_cnt},  32'd0);
    cycles(1);
    rst = 1'b0;
    cycles(1);
`endif

    chk("left_c1", exp_c1.size(), 32'd0);
    chk("left_c2", exp_c2.size(), 32'd0);
    chk("left_p",  exp_p.size(),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tree_router3.md
Name: tree_router3

Overview:
- 3-port node of a binary-tree NoC: two child ports (C1, C2) and one parent port (P), each with a 32-bit valid/ready input and output.
- Each input has a route decoder (switch) that steers a packet to one of the two other outputs.
- Each output has a 2:1 round-robin merge feeding a one-entry output register.
- The node never returns a packet to the port it arrived on.

Parameters:
- WIDTH, 32, packet width.
- ADDR_W, 3, destination address width.
- DEST_LSB, 24, bit position of the destination field; dest = pkt[DEST_LSB+ADDR_W-1:DEST_LSB].
- ADDRESS, 3'b000, this node's subtree address.
- MASK, 3'b000, address bits that identify this node's subtree; must contain at least one zero bit.

Ports:
- clk, in, 1, clock; all state on rising edge.
- rst, in, 1, asynchronous active-high reset.
- c1_in_valid / c1_in_ready / c1_in_data, in / out / in, 1 / 1 / WIDTH, packets from child 1.
- c2_in_valid / c2_in_ready / c2_in_data, in / out / in, 1 / 1 / WIDTH, packets from child 2.
- p_in_valid / p_in_ready / p_in_data, in / out / in, 1 / 1 / WIDTH, packets from parent.
- c1_out_valid / c1_out_ready / c1_out_data, out / in / out, 1 / 1 / WIDTH, packets to child 1.
- c2_out_valid / c2_out_ready / c2_out_data, out / in / out, 1 / 1 / WIDTH, packets to child 2.
- p_out_valid / p_out_ready / p_out_data, out / in / out, 1 / 1 / WIDTH, packets to parent.

Behaviour:
- Handshake: a transfer occurs on a clk edge where valid && ready.
  - A sender holds valid and data stable until the transfer.
  - in_ready may depend combinationally on in_valid/in_data and out_ready.
- Child routing (C1 or C2 input):
  - If (dest & MASK) == (ADDRESS & MASK), the packet goes to the sibling child output (C1 in -> C2 out, C2 in -> C1 out).
  - Otherwise it goes to P out.
- Parent routing (P input):
  - Select bit index k = highest bit position where MASK is 0.
  - dest[k]==0 -> C1 out; dest[k]==1 -> C2 out.
  - Example: MASK=110 gives k=0.
- Merge sources per output:
  - C1 out: {C2 in, P in}.
  - C2 out: {C1 in, P in}.
  - P out: {C1 in, C2 in}.
- Merge operation:
  - A source requests an output when its in_valid is high and its decoded target is that output.
  - Output register is free when out_valid==0 or out_ready==1 in the same cycle.
  - If free and one source requests, grant it; if both request, grant by round-robin pointer (the source not granted last time wins).
  - The pointer updates only on a grant.
- in_ready equals that input's grant. Data is never duplicated or dropped.
- Latency: a packet accepted at edge N is presented at the output (valid) after edge N; one cycle minimum.
- Throughput: 1 packet/cycle per output under continuous out_ready.
- Stall: out_valid holds and data stays stable while out_ready==0; competing inputs see ready=0.
- Independence: the three outputs operate concurrently; an input blocked on a full output does not block other inputs.
- Reset (async, any time): all out_valid=0, out_data=0, round-robin pointers to first-listed source; in-flight packets are discarded.
  - in_ready is 0 while rst is high.
- Data payload is passed unmodified.

Optional Feature:
- ROUTER_STATS_EN defined: adds outputs c1_out_cnt, c2_out_cnt, p_out_cnt (16 bits each).
  - Each counts completed output transfers, saturates at 16'hFFFF and resets to 0.
- ROUTER_STATS_EN not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package tree_router_pkg holds:
  - WIDTH/ADDR_W/DEST_LSB defaults and the packet typedef (logic [WIDTH-1:0]).
  - Port enum {PORT_C1, PORT_C2, PORT_P}.
  - Function dest_of(pkt).
  - Function route(in_port, dest, ADDRESS, MASK) returning the target port.
- One sub-module router_merge2: a 2:1 round-robin arbiter with a one-entry output register and valid/ready, instantiated three times.

Test Plan:
- ADDRESS=010, MASK=110; P in sends 0x01000009, 0x0200000C, 0x0300000F, out_ready all 1 -> C2 out gets 0x01000009, C1 out gets 0x0200000C, C2 out gets 0x0300000F, each 1 cycle after acceptance, in order.
- Same config; C1 in sends 0x03000001 (in subtree) -> C2 out; C1 in sends 0x05000001 (out of subtree) -> P out; nothing ever appears on C1 out.
- C1 in and C2 in both send out-of-subtree packets to P out for 4 cycles -> P out alternates C1, C2, C1, C2 with no loss.
- c2_out_ready held 0 while P in sends dest 001 -> c2_out_valid stays 1 with data stable; p_in_ready=0; a concurrent C2-in packet to C1 out still passes.
- rst asserted mid-stream between clock edges -> all out_valid drop to 0 immediately; after release, a new packet routes correctly with the first-listed source granted first.
- With ROUTER_STATS_EN: send 3 packets to C2 out -> c2_out_cnt=3, others unchanged; reset clears all counts to 0.
